lc3_regfile_sb: RTL and testbench
=================================

Name: lc3_regfile_sb

Overview:
- Parametrised multi-port general-purpose register file for the LC-3 datapath, with write-through bypass, a per-register busy scoreboard and an NZP condition-code register.
- Supersedes the fixed 8x16, 1-write/2-read register matrix.
- Sits between decode (read-index and issue inputs) and writeback (ALU and load-return write ports).
- Decode reads operands and stall status in the same cycle.

Parameters:
DATA_W, 16, register width in bits
NREG, 8, number of registers (power of two, >=2)
NRD, 2, number of read ports
NWR, 2, number of write ports; higher port index has higher priority
BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return stored value only
IDX_W, $clog2(NREG), derived register-index width (localparam)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
wr_en  in  NWR  per-port write enable
wr_idx  in  NWR*IDX_W  packed write indices; port k at [k*IDX_W +: IDX_W]
wr_data  in  NWR*DATA_W  packed write data
ld_cc  in  1  update NZP from write port 0 data
iss_vld  in  1  instruction issued that will write iss_idx
iss_idx  in  IDX_W  destination register of issued instruction
rd_idx  in  NRD*IDX_W  packed read indices
rd_data  out  NRD*DATA_W  packed read data (combinational)
rd_busy  out  NRD  read operand not yet available (combinational)
nzp  out  3  condition codes {N,Z,P}, registered
busy_vec  out  NREG  scoreboard state, registered

Behaviour:
- Reset (rst=1 at clk edge):
  - All registers <= 0, busy_vec <= 0, nzp <= 3'b010.
  - rst overrides every write, issue and ld_cc in the same cycle.
  - After reset, rd_data = 0 and rd_busy = 0 for all ports.
- Write:
  - Registered; wr_data[k] is stored at wr_idx[k] on the edge where wr_en[k]=1.
  - Two ports writing the same index in one cycle: the highest port number wins.
  - Different indices: all writes commit.
- Read:
  - Combinational, zero latency.
  - BYPASS=1: if any enabled write port targets rd_idx[j] this cycle, rd_data[j] = that port's wr_data (highest matching port). Otherwise the stored value.
  - BYPASS=0: always the stored value; the new value is visible the cycle after the edge.
- Scoreboard:
  - Next busy[i] = (busy[i] & ~wclr[i]) | (iss_vld & iss_idx==i), where wclr[i] = any wr_en[k] with wr_idx[k]==i.
  - Issue and write to the same register in the same cycle: busy ends set (new producer wins).
  - Re-issue to an already busy register: stays busy. Single bit, no count; one write clears it.
  - A write to a non-busy register is legal and leaves busy=0.
- rd_busy[j]:
  - = busy[rd_idx[j]] & ~(BYPASS & wclr[rd_idx[j]]).
  - A same-cycle write releases the stall only when BYPASS=1.
  - Not affected by a same-cycle issue.
- NZP:
  - On an edge with ld_cc=1 and wr_en[0]=1, source is wr_data[0]: N=msb, Z=(data==0), P=otherwise. Exactly one bit is set.
  - ld_cc=1 with wr_en[0]=0: nzp holds.
  - ld_cc does not depend on which port wins a same-index write conflict.
- No X propagation: all outputs are driven every cycle. Out-of-range indices cannot occur because NREG is a power of two.

Decomposition:
- Shared package lc3_pkg:
  - NZP bit positions (CC_N=2, CC_Z=1, CC_P=0) and the reset value CC_RST=3'b010.
  - DRMUX/SR1MUX encodings and the fixed R6/R7 index constants, for the decode-side index-select logic that feeds this block.
- One sub-module, lc3_wr_arb:
  - Per-register one-hot write match plus priority select across NWR ports.
  - Outputs wclr[NREG] and the winning data per register.
  - Reused by both the storage update and the bypass path.

Test Plan:
1. Reset then read: rst=1 for 2 cycles, rd_idx={3,0} -> rd_data={0,0}, rd_busy=0, nzp=3'b010, busy_vec=0.
2. Write then bypass read: wr_en=2'b01, wr_idx[0]=5, wr_data[0]=16'h1234, rd_idx[0]=5 in the same cycle -> rd_data[0]=16'h1234 with BYPASS=1. With BYPASS=0 -> 0 that cycle, 16'h1234 the next.
3. Write conflict: both ports write R2 (port0 16'hAAAA, port1 16'h5555) -> R2 reads 16'h5555 next cycle.
4. Scoreboard: iss_vld with iss_idx=4 -> busy_vec[4]=1 and rd_busy=1 when reading R4. A later write to R4 -> rd_busy=0 that cycle (BYPASS=1) and busy_vec[4]=0 after. Issue plus write to R4 in the same cycle -> busy_vec[4]=1.
5. CC: ld_cc with wr_data[0]=16'h8000 -> nzp=100; 16'h0000 -> 010; 16'h0001 -> 001. ld_cc with wr_en[0]=0 -> nzp unchanged.
6. Reset mid-operation: rst=1 coinciding with a write of 16'hBEEF to R7, iss_vld to R1 and ld_cc -> R7=0, busy_vec=0, nzp=3'b010.

Source files
------------

// File: rtl/lc3_pkg.sv
// Shared LC-3 datapath definitions: condition-code layout and the decode-side
// register-select encodings that produce the indices fed to the register file.
package lc3_pkg;

    localparam int       CC_N   = 2;
    localparam int       CC_Z   = 1;
    localparam int       CC_P   = 0;
    localparam logic [2:0] CC_RST = 3'b010;

    // Fixed register indices used by DRMUX/SR1MUX (stack pointer and link).
    localparam logic [2:0] R6_IDX = 3'd6;
    localparam logic [2:0] R7_IDX = 3'd7;

    typedef enum logic [1:0] {
        DRMUX_IR11_9 = 2'b00,
        DRMUX_R7     = 2'b01,
        DRMUX_R6     = 2'b10
    } drmux_e;

    typedef enum logic [1:0] {
        SR1MUX_IR11_9 = 2'b00,
        SR1MUX_IR8_6  = 2'b01,
        SR1MUX_R6     = 2'b10
    } sr1mux_e;

    // Exactly one of N/Z/P is set; N takes the sign bit, Z the all-zero test.
    function automatic logic [2:0] cc_encode(input logic neg, input logic zero);
        logic [2:0] cc;
        cc = '0;
        if (neg)
            cc[CC_N] = 1'b1;
        else if (zero)
            cc[CC_Z] = 1'b1;
        else
            cc[CC_P] = 1'b1;
        return cc;
    endfunction

endpackage

// File: rtl/lc3_wr_arb.sv
// Per-register write match and priority select across the write ports;
// shared by the storage update and the read bypass path.
module lc3_wr_arb #(
    parameter  int DATA_W = 16,
    parameter  int NREG   = 8,
    parameter  int NWR    = 2,
    localparam int IDX_W  = $clog2(NREG)
) (
    input  logic [NWR-1:0]        wr_en,
    input  logic [NWR*IDX_W-1:0]  wr_idx,
    input  logic [NWR*DATA_W-1:0] wr_data,
    output logic [NREG-1:0]       wclr,
    output logic [DATA_W-1:0]     win_data [NREG]
);

    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
        logic              w_hit;
        logic [DATA_W-1:0] w_data;

        // Ascending scan so the highest-numbered matching port is the last assignment.
        always_comb begin
            w_hit  = 1'b0;
            w_data = '0;
            for (int k = 0; k < NWR; k++) begin
                if (wr_en[k] && (wr_idx[k*IDX_W +: IDX_W] == IDX_W'(gi))) begin
                    w_hit  = 1'b1;
                    w_data = wr_data[k*DATA_W +: DATA_W];
                end
            end
        end

        assign wclr[gi]     = w_hit;
        assign win_data[gi] = w_data;
    end

endmodule

// File: rtl/lc3_regfile_sb.sv
// LC-3 multi-port register file with optional write-through bypass,
// single-bit busy scoreboard per register and an NZP condition-code register.
module lc3_regfile_sb
    import lc3_pkg::*;
#(
    parameter  int DATA_W = 16,
    parameter  int NREG   = 8,
    parameter  int NRD    = 2,
    parameter  int NWR    = 2,
    parameter  int BYPASS = 1,
    localparam int IDX_W  = $clog2(NREG)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NWR-1:0]        wr_en,
    input  logic [NWR*IDX_W-1:0]  wr_idx,
    input  logic [NWR*DATA_W-1:0] wr_data,
    input  logic                  ld_cc,
    input  logic                  iss_vld,
    input  logic [IDX_W-1:0]      iss_idx,
    input  logic [NRD*IDX_W-1:0]  rd_idx,
    output logic [NRD*DATA_W-1:0] rd_data,
    output logic [NRD-1:0]        rd_busy,
    output logic [2:0]            nzp,
    output logic [NREG-1:0]       busy_vec
);

    localparam logic BYP = (BYPASS != 0);

    logic [DATA_W-1:0] r_regs [NREG];
    logic [NREG-1:0]   r_busy;
    logic [2:0]        r_nzp;

    logic [NREG-1:0]   w_wclr;
    logic [DATA_W-1:0] w_win_data [NREG];
    logic [NREG-1:0]   w_busy_next;
    logic [DATA_W-1:0] w_cc_src;

    lc3_wr_arb #(
        .DATA_W (DATA_W),
        .NREG   (NREG),
        .NWR    (NWR)
    ) u_wr_arb (
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .wr_data  (wr_data),
        .wclr     (w_wclr),
        .win_data (w_win_data)
    );

    // A same-cycle issue is applied after the clear, so the new producer wins.
    for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
        assign w_busy_next[gi] = (r_busy[gi] & ~w_wclr[gi])
                               | (iss_vld & (iss_idx == IDX_W'(gi)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                r_regs[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++)
                if (w_wclr[i])
                    r_regs[i] <= w_win_data[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_busy <= '0;
        else
            r_busy <= w_busy_next;
    end

    // Condition codes always follow port 0, independent of conflict resolution.
    assign w_cc_src = wr_data[DATA_W-1:0];

    always_ff @(posedge clk) begin
        if (rst)
            r_nzp <= CC_RST;
        else if (ld_cc && wr_en[0])
            r_nzp <= cc_encode(w_cc_src[DATA_W-1], w_cc_src == '0);
    end

    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
        logic [IDX_W-1:0] w_ridx;
        logic             w_fwd;

        assign w_ridx = rd_idx[gi*IDX_W +: IDX_W];
        assign w_fwd  = BYP & w_wclr[w_ridx];

        assign rd_data[gi*DATA_W +: DATA_W] = w_fwd ? w_win_data[w_ridx] : r_regs[w_ridx];
        assign rd_busy[gi]                  = r_busy[w_ridx] & ~w_fwd;
    end

    assign nzp      = r_nzp;
    assign busy_vec = r_busy;

endmodule

// File: tb/tb_lc3_regfile_sb.sv
// Bench for lc3_regfile_sb: bypass and non-bypass instances share stimulus and
// are checked against a behavioural register-file model.
module tb_lc3_regfile_sb;

    localparam int DW  = 16;
    localparam int NR  = 8;
    localparam int NRD = 2;
    localparam int NWR = 2;
    localparam int IW  = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [NWR-1:0]    wr_en;
    logic [NWR*IW-1:0] wr_idx;
    logic [NWR*DW-1:0] wr_data;
    logic              ld_cc;
    logic              iss_vld;
    logic [IW-1:0]     iss_idx;
    logic [NRD*IW-1:0] rd_idx;

    logic [NRD*DW-1:0] rd_data_b, rd_data_n;
    logic [NRD-1:0]    rd_busy_b, rd_busy_n;
    logic [2:0]        nzp_b, nzp_n;
    logic [NR-1:0]     busy_vec_b, busy_vec_n;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] m_regs [NR];
    logic [NR-1:0] m_busy;
    logic [2:0]    m_nzp;

    always #5 clk = ~clk;

    lc3_regfile_sb #(.DATA_W(DW), .NREG(NR), .NRD(NRD), .NWR(NWR), .BYPASS(1)) dut_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
        .ld_cc(ld_cc), .iss_vld(iss_vld), .iss_idx(iss_idx), .rd_idx(rd_idx),
        .rd_data(rd_data_b), .rd_busy(rd_busy_b), .nzp(nzp_b), .busy_vec(busy_vec_b)
    );

    lc3_regfile_sb #(.DATA_W(DW), .NREG(NR), .NRD(NRD), .NWR(NWR), .BYPASS(0)) dut_n (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
        .ld_cc(ld_cc), .iss_vld(iss_vld), .iss_idx(iss_idx), .rd_idx(rd_idx),
        .rd_data(rd_data_n), .rd_busy(rd_busy_n), .nzp(nzp_n), .busy_vec(busy_vec_n)
    );

    // Is register r written by any enabled port this cycle?
    function automatic bit m_written(input logic [IW-1:0] r);
        bit hit = 0;
        for (int k = 0; k < NWR; k++)
            if (wr_en[k] && wr_idx[k*IW +: IW] == r) hit = 1;
        return hit;
    endfunction

    function automatic logic [DW-1:0] exp_rd(input int j, input bit byp);
        logic [IW-1:0] r = rd_idx[j*IW +: IW];
        logic [DW-1:0] v = m_regs[r];
        if (byp)
            for (int k = 0; k < NWR; k++)
                if (wr_en[k] && wr_idx[k*IW +: IW] == r) v = wr_data[k*DW +: DW];
        return v;
    endfunction

    function automatic logic exp_busy(input int j, input bit byp);
        logic [IW-1:0] r = rd_idx[j*IW +: IW];
        return m_busy[r] && !(byp && m_written(r));
    endfunction

    // Advance one clock edge, updating the model from the inputs held across it.
    task automatic tick();
        logic [DW-1:0] nregs [NR];
        logic [NR-1:0] nbusy;
        logic [2:0]    ncc;
        logic [DW-1:0] d0;
        for (int i = 0; i < NR; i++) nregs[i] = m_regs[i];
        nbusy = m_busy;
        ncc   = m_nzp;
        if (rst) begin
            for (int i = 0; i < NR; i++) nregs[i] = '0;
            nbusy = '0;
            ncc   = 3'b010;
        end else begin
            for (int k = 0; k < NWR; k++)
                if (wr_en[k]) nregs[wr_idx[k*IW +: IW]] = wr_data[k*DW +: DW];
            for (int i = 0; i < NR; i++) begin
                nbusy[i] = (m_busy[i] && !m_written(IW'(i))) || (iss_vld && iss_idx == IW'(i));
            end
            if (ld_cc && wr_en[0]) begin
                d0  = wr_data[DW-1:0];
                ncc = d0[DW-1] ? 3'b100 : (d0 == 0) ? 3'b010 : 3'b001;
            end
        end
        @(posedge clk);
        for (int i = 0; i < NR; i++) m_regs[i] = nregs[i];
        m_busy = nbusy;
        m_nzp  = ncc;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst = 0; wr_en = '0; wr_idx = '0; wr_data = '0;
        ld_cc = 0; iss_vld = 0; iss_idx = '0; rd_idx = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1; wr_en = 2'b11; wr_idx = {3'd3, 3'd0}; wr_data = 32'hDEAD_BEEF;
        iss_vld = 1; iss_idx = 3'd3; ld_cc = 1;
        tick(); tick();
        idle_inputs();
        rd_idx = {3'd3, 3'd0};
        #1;
        checks++;
        if (rd_data_b !== '0 || rd_data_n !== '0) begin
            errors++; $display("FAIL reset_rd_data got=%h/%h exp=0", rd_data_b, rd_data_n);
        end
        checks++;
        if (rd_busy_b !== '0 || rd_busy_n !== '0) begin
            errors++; $display("FAIL reset_rd_busy got=%b/%b exp=0", rd_busy_b, rd_busy_n);
        end
        checks++;
        if (nzp_b !== 3'b010 || nzp_n !== 3'b010) begin
            errors++; $display("FAIL reset_nzp got=%b/%b exp=010", nzp_b, nzp_n);
        end
        checks++;
        if (busy_vec_b !== '0 || busy_vec_n !== '0) begin
            errors++; $display("FAIL reset_busy_vec got=%b/%b exp=0", busy_vec_b, busy_vec_n);
        end
        $display("test_reset done");
    endtask

    task automatic test_bypass();
        idle_inputs();
        wr_en = 2'b01; wr_idx[2:0] = 3'd5; wr_data[15:0] = 16'h1234;
        rd_idx[2:0] = 3'd5;
        #1;
        checks++;
        if (rd_data_b[15:0] !== 16'h1234) begin
            errors++; $display("FAIL bypass_same_cycle got=%h exp=1234", rd_data_b[15:0]);
        end
        checks++;
        if (rd_data_n[15:0] !== 16'h0000) begin
            errors++; $display("FAIL nobypass_same_cycle got=%h exp=0000", rd_data_n[15:0]);
        end
        tick();
        wr_en = '0;
        #1;
        checks++;
        if (rd_data_n[15:0] !== 16'h1234 || rd_data_b[15:0] !== 16'h1234) begin
            errors++; $display("FAIL bypass_next_cycle got=%h/%h exp=1234", rd_data_b[15:0], rd_data_n[15:0]);
        end
        $display("test_bypass done");
    endtask

    task automatic test_conflict();
        idle_inputs();
        wr_en = 2'b11; wr_idx = {3'd2, 3'd2}; wr_data = {16'h5555, 16'hAAAA};
        rd_idx = {3'd2, 3'd2};
        #1;
        checks++;
        if (rd_data_b[31:16] !== 16'h5555) begin
            errors++; $display("FAIL conflict_bypass got=%h exp=5555", rd_data_b[31:16]);
        end
        tick();
        wr_en = '0;
        #1;
        checks++;
        if (rd_data_b[15:0] !== 16'h5555 || rd_data_n[31:16] !== 16'h5555) begin
            errors++; $display("FAIL conflict_stored got=%h/%h exp=5555", rd_data_b[15:0], rd_data_n[31:16]);
        end
        $display("test_conflict done");
    endtask

    task automatic test_scoreboard();
        idle_inputs();
        iss_vld = 1; iss_idx = 3'd4; rd_idx = {3'd3, 3'd4};
        #1;
        checks++;
        if (rd_busy_b !== 2'b00 || rd_busy_n !== 2'b00) begin
            errors++; $display("FAIL sb_issue_no_same_cycle got=%b/%b exp=00", rd_busy_b, rd_busy_n);
        end
        tick();
        iss_vld = 0;
        #1;
        checks++;
        if (busy_vec_b[4] !== 1'b1 || rd_busy_b[0] !== 1'b1 || rd_busy_n[0] !== 1'b1) begin
            errors++; $display("FAIL sb_busy_set got=%b/%b/%b exp=1", busy_vec_b[4], rd_busy_b[0], rd_busy_n[0]);
        end
        wr_en = 2'b10; wr_idx = {3'd4, 3'd0}; wr_data = {16'h0F0F, 16'h0000};
        #1;
        checks++;
        if (rd_busy_b[0] !== 1'b0 || rd_busy_n[0] !== 1'b1) begin
            errors++; $display("FAIL sb_write_release got=%b/%b exp=0/1", rd_busy_b[0], rd_busy_n[0]);
        end
        tick();
        wr_en = '0;
        #1;
        checks++;
        if (busy_vec_b[4] !== 1'b0 || busy_vec_n[4] !== 1'b0) begin
            errors++; $display("FAIL sb_cleared got=%b/%b exp=0", busy_vec_b[4], busy_vec_n[4]);
        end
        iss_vld = 1; iss_idx = 3'd4; wr_en = 2'b01; wr_idx = {3'd0, 3'd4}; wr_data = 32'h0000_0777;
        tick();
        idle_inputs();
        #1;
        checks++;
        if (busy_vec_b[4] !== 1'b1 || busy_vec_n[4] !== 1'b1) begin
            errors++; $display("FAIL sb_issue_and_write got=%b/%b exp=1", busy_vec_b[4], busy_vec_n[4]);
        end
        $display("test_scoreboard done");
    endtask

    task automatic test_cc();
        logic [15:0] vals [3];
        logic [2:0]  exps [3];
        vals[0] = 16'h8000; exps[0] = 3'b100;
        vals[1] = 16'h0000; exps[1] = 3'b010;
        vals[2] = 16'h0001; exps[2] = 3'b001;
        for (int t = 0; t < 3; t++) begin
            idle_inputs();
            ld_cc = 1; wr_en = 2'b11; wr_idx = {3'd1, 3'd1};
            wr_data = {~vals[t], vals[t]};
            tick();
            #1;
            checks++;
            if (nzp_b !== exps[t] || nzp_n !== exps[t]) begin
                errors++; $display("FAIL cc_load val=%h got=%b/%b exp=%b", vals[t], nzp_b, nzp_n, exps[t]);
            end
        end
        idle_inputs();
        ld_cc = 1; wr_en = 2'b10; wr_data = 32'h8000_8000;
        tick();
        #1;
        checks++;
        if (nzp_b !== 3'b001 || nzp_n !== 3'b001) begin
            errors++; $display("FAIL cc_hold got=%b/%b exp=001", nzp_b, nzp_n);
        end
        $display("test_cc done");
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        rst = 1; wr_en = 2'b01; wr_idx = {3'd0, 3'd7}; wr_data = 32'h0000_BEEF;
        iss_vld = 1; iss_idx = 3'd1; ld_cc = 1;
        tick();
        idle_inputs();
        rd_idx = {3'd1, 3'd7};
        #1;
        checks++;
        if (rd_data_b[15:0] !== 16'h0000 || rd_data_n[15:0] !== 16'h0000) begin
            errors++; $display("FAIL rstmid_r7 got=%h/%h exp=0000", rd_data_b[15:0], rd_data_n[15:0]);
        end
        checks++;
        if (busy_vec_b !== '0 || busy_vec_n !== '0 || nzp_b !== 3'b010 || nzp_n !== 3'b010) begin
            errors++; $display("FAIL rstmid_state busy=%b/%b nzp=%b/%b exp=0/010",
                               busy_vec_b, busy_vec_n, nzp_b, nzp_n);
        end
        $display("test_reset_mid done");
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst     = ($urandom_range(0, 39) == 0);
            wr_en   = NWR'($urandom);
            wr_idx  = NWR*IW'($urandom);
            wr_data = {$urandom_range(0, 3) == 0 ? 16'h0 : 16'($urandom),
                       $urandom_range(0, 3) == 0 ? 16'h0 : 16'($urandom)};
            ld_cc   = $urandom_range(0, 1) == 1;
            iss_vld = $urandom_range(0, 2) != 0;
            iss_idx = IW'($urandom);
            rd_idx  = NRD*IW'($urandom);
            #1;
            for (int j = 0; j < NRD; j++) begin
                checks++;
                if (rd_data_b[j*DW +: DW] !== exp_rd(j, 1) || rd_data_n[j*DW +: DW] !== exp_rd(j, 0)) begin
                    errors++; $display("FAIL rand_rd_data cyc=%0d port=%0d got=%h/%h exp=%h/%h", c, j,
                                       rd_data_b[j*DW +: DW], rd_data_n[j*DW +: DW], exp_rd(j, 1), exp_rd(j, 0));
                end
                checks++;
                if (rd_busy_b[j] !== exp_busy(j, 1) || rd_busy_n[j] !== exp_busy(j, 0)) begin
                    errors++; $display("FAIL rand_rd_busy cyc=%0d port=%0d got=%b/%b exp=%b/%b", c, j,
                                       rd_busy_b[j], rd_busy_n[j], exp_busy(j, 1), exp_busy(j, 0));
                end
            end
            checks++;
            if (busy_vec_b !== m_busy || busy_vec_n !== m_busy) begin
                errors++; $display("FAIL rand_busy_vec cyc=%0d got=%b/%b exp=%b", c, busy_vec_b, busy_vec_n, m_busy);
            end
            checks++;
            if (nzp_b !== m_nzp || nzp_n !== m_nzp) begin
                errors++; $display("FAIL rand_nzp cyc=%0d got=%b/%b exp=%b", c, nzp_b, nzp_n, m_nzp);
            end
            tick();
        end
        $display("test_random done");
    endtask

    initial begin
        for (int i = 0; i < NR; i++) m_regs[i] = '0;
        m_busy = '0;
        m_nzp  = 3'b010;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_bypass();
        test_conflict();
        test_scoreboard();
        test_cc();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
